wb_quad_velocity: RTL and testbench
===================================

// Module: wb_quad_velocity
// PURPOSE
//  Downstream of the quadrature encoder counter: consumes its 32-bit position count and
//  produces a signed velocity (count delta per programmable sample window). Exposes
//  velocity, window length, sample counter and status as Wishbone registers for the CPU.
// PARAMETERS
//  PERIOD_W        24          width of window-length register (cycles)
//  DEFAULT_PERIOD  24'd100000  window length after reset (cycles)
// PORTS
//  i_clk           in   1   system clock
//  i_reset         in   1   synchronous, active-high reset
//  i_wb_cyc        in   1   Wishbone cycle
//  i_wb_stb        in   1   Wishbone strobe
//  i_wb_we         in   1   Wishbone write enable
//  i_wb_addr       in   30  word address; only [1:0] decoded
//  i_wb_data       in   32  write data
//  i_wb_sel        in   4   byte selects; ignored, all writes are full-word
//  o_wb_ack        out  1   one-cycle acknowledge
//  o_wb_stall      out  1   high while not IDLE
//  o_wb_data       out  32  read data, valid with ack, else 0
//  i_count         in   32  encoder position count
//  i_count_clr     in   1   pulse: encoder count is being cleared this cycle (reads 0 next cycle)
//  o_velocity      out  32  signed delta of last completed window
//  o_sample_valid  out  1   one-cycle pulse when o_velocity updates
// BEHAVIOUR
//  Reset (sync, i_reset=1): o_velocity=0, o_sample_valid=0, prev=0, period=DEFAULT_PERIOD,
//   tick=DEFAULT_PERIOD-1, sample_cnt=0, status=0, WB state IDLE, o_wb_ack=0, o_wb_data=0.
//  Window tick: down-counter tick; when tick==0 -> sample, reload tick=period-1; else tick-1.
//  Sample: o_velocity <= i_count - prev (32-bit modular, read as two's complement);
//   prev <= i_count; sample_cnt <= sample_cnt+1 (wraps 2^32-1 -> 0); status.new <= 1;
//   o_sample_valid=1 next cycle only.
//  i_count_clr: prev <= 0, status.disc <= 1 (sticky). Same cycle as sample: sample uses
//   current i_count for o_velocity, but prev <= 0 (clear wins).
//  Registers (addr[1:0]): 0 VELOCITY (RO), 1 PERIOD (RW, zero-extended), 2 SAMPLE_CNT (RO),
//   3 STATUS (RO) = {30'b0, disc, new}. Writes to RO addresses ignored but acked.
//  PERIOD write: period <= data[PERIOD_W-1:0], value 0 clamped to 1; tick <= new period-1
//   (window restarts); prev <= i_count; no sample emitted that cycle.
//  WB FSM: IDLE --(cyc&stb)--> ACK (latch read data / perform write) --> IDLE.
//   Latency: ack exactly 1 cycle after accepted strobe; stall=1 during ACK; one transaction
//   per 2 cycles. In ACK o_wb_data=latched value; back in IDLE o_wb_data=0.
//  STATUS read: returns bits as sampled at accept; clears new and disc in same cycle,
//   except a bit set by an event in that very cycle stays set (set wins over clear).
//  Reset mid-transaction: FSM to IDLE, no ack issued, pending write discarded.
//  Period=1: sample every cycle; o_sample_valid may stay high continuously.
// STRUCTURE
//  Package wb_quad_pkg: register address localparams (REG_VEL=0, REG_PERIOD=1, REG_SCNT=2,
//   REG_STAT=3), STATUS bit indices, WB state enum {IDLE, WBACK}.
//  Sub-module wb_quad_window_tick: period register + down-counter, outputs tick pulse,
//   inputs load/value; top holds delta datapath, status and WB FSM.
// TESTING
//  1 Reset, PERIOD=4 write, i_count steps +3 per window -> o_velocity=3, valid every 4 cycles.
//  2 i_count decreasing by 5 per window -> o_velocity=32'hFFFF_FFFB (-5).
//  3 prev=32'hFFFF_FFFE, i_count=32'h0000_0002 at sample -> o_velocity=4 (wrap).
//  4 i_count_clr mid-window with count 10->0, then +7 -> o_velocity=7, STATUS=2'b11; read
//    STATUS again -> 2'b00.
//  5 Write PERIOD=0 -> readback 1, sample every cycle; write PERIOD mid-window -> window restarts.
//  6 WB: stb held 3 cycles -> ack 1 cycle after accept, stall during ack; reset asserted in
//    ACK -> no ack, o_wb_data=0; SAMPLE_CNT read after 5 samples -> 5.

Source files
------------

// File: rtl/wb_quad_pkg.sv
// Shared register map, status bit positions and Wishbone FSM states for the quadrature velocity block.
package wb_quad_pkg;

  localparam logic [1:0] REG_VEL    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_SCNT   = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  localparam int STAT_NEW  = 0;
  localparam int STAT_DISC = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WBACK = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_quad_window_tick.sv
// Sample-window timer: holds the period and pulses o_tick when the down-counter hits zero.
// A load restarts the window and suppresses the tick in that cycle.
module wb_quad_window_tick #(
  parameter int                  PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd100000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_load_val,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_tick;
  logic [PERIOD_W-1:0] w_new_period;

  // A zero-length window is meaningless, so it is treated as one cycle.
  assign w_new_period = (i_load_val == '0) ? PERIOD_W'(1) : i_load_val;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_period <= DEFAULT_PERIOD;
      r_tick   <= DEFAULT_PERIOD - PERIOD_W'(1);
    end else if (i_load) begin
      r_period <= w_new_period;
      r_tick   <= w_new_period - PERIOD_W'(1);
    end else if (r_tick == '0) begin
      r_tick   <= r_period - PERIOD_W'(1);
    end else begin
      r_tick   <= r_tick - PERIOD_W'(1);
    end
  end

  assign o_period = r_period;
  assign o_tick   = (r_tick == '0) && !i_load;

endmodule

// File: rtl/wb_quad_velocity.sv
// Encoder velocity: count delta per programmable window, read via Wishbone.
// Ack one cycle after accept; stall held during the ack cycle, so one transaction per two cycles.
module wb_quad_velocity
  import wb_quad_pkg::*;
#(
  parameter int                  PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  input  logic [31:0] i_count,
  input  logic        i_count_clr,
  output logic [31:0] o_velocity,
  output logic        o_sample_valid
);

  wb_state_t           r_state, w_next;
  logic                w_accept, w_stat_rd, w_wr_period, w_tick;
  logic [PERIOD_W-1:0] w_period, r_wr_data;
  logic [31:0]         w_rd_mux, r_rdata, r_prev, r_scnt, r_velocity;
  logic [1:0]          r_addr;
  logic                r_we, r_stat_new, r_stat_disc, r_sample_valid;
  logic                w_unused;

  assign w_unused    = ^{i_wb_sel, i_wb_addr[29:2], i_wb_data};
  assign w_accept    = (r_state == IDLE) && i_wb_cyc && i_wb_stb;
  assign w_stat_rd   = w_accept && !i_wb_we && (i_wb_addr[1:0] == REG_STAT);
  assign w_wr_period = (r_state == WBACK) && r_we && (r_addr == REG_PERIOD);

  wb_quad_window_tick #(
    .PERIOD_W      (PERIOD_W),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_tick (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_wr_period),
    .i_load_val(r_wr_data),
    .o_period  (w_period),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_rd_mux = '0;
    case (i_wb_addr[1:0])
      REG_VEL:    w_rd_mux = r_velocity;
      REG_PERIOD: w_rd_mux = 32'(w_period);
      REG_SCNT:   w_rd_mux = r_scnt;
      REG_STAT:   w_rd_mux = {30'b0, r_stat_disc, r_stat_new};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_wb_cyc && i_wb_stb) w_next = WBACK;
      WBACK: w_next = IDLE;
    endcase
  end

  // Ack and data are gated by reset so a reset landing in the ack cycle hides the response.
  always_comb begin
    o_wb_stall = (r_state != IDLE);
    o_wb_ack   = (r_state == WBACK) && !i_reset;
    o_wb_data  = o_wb_ack ? r_rdata : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rdata   <= '0;
    end else if (w_accept) begin
      r_we      <= i_wb_we;
      r_addr    <= i_wb_addr[1:0];
      r_wr_data <= i_wb_data[PERIOD_W-1:0];
      r_rdata   <= i_wb_we ? '0 : w_rd_mux;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_velocity     <= '0;
      r_sample_valid <= 1'b0;
      r_prev         <= '0;
      r_scnt         <= '0;
      r_stat_new     <= 1'b0;
      r_stat_disc    <= 1'b0;
    end else begin
      r_sample_valid <= w_tick;
      if (w_tick) begin
        r_velocity <= i_count - r_prev;
        r_prev     <= i_count;
        r_scnt     <= r_scnt + 32'd1;
      end
      if (w_wr_period) r_prev <= i_count;
      // Encoder clear overrides any baseline captured in the same cycle.
      if (i_count_clr) r_prev <= '0;
      r_stat_new  <= w_tick | (r_stat_new & !w_stat_rd);
      r_stat_disc <= i_count_clr | (r_stat_disc & !w_stat_rd);
    end
  end

  assign o_velocity     = r_velocity;
  assign o_sample_valid = r_sample_valid;

endmodule

// File: tb/tb_wb_quad_velocity.sv
// Directed bench for wb_quad_velocity: windowed deltas, wrap, clear, status, period and WB handshake.
module tb_wb_quad_velocity;
  import wb_quad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] cnt = '0;
  logic        cnt_clr = 1'b0;
  logic        ack, stall, valid;
  logic [31:0] rdat, vel, d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_quad_velocity dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .i_wb_sel(4'hF),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
    .i_count(cnt), .i_count_clr(cnt_clr),
    .o_velocity(vel), .o_sample_valid(valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] v);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = {28'b0, a}; wdat = v;
    step;
    chk("wr_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] v);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {28'b0, a};
    step;
    chk("rd_ack", {31'b0, ack}, 32'd1);
    v = rdat;
    cyc = 1'b0; stb = 1'b0;
    step;
  endtask

  // Assumes period 4 and that the previous edge started a fresh window.
  task automatic run_window(input logic [31:0] newc, input logic [31:0] exp_vel);
    int early;
    early = 0;
    cnt = newc;
    repeat (3) begin
      step;
      if (valid) early++;
    end
    step;
    chk("early_valid", 32'(early), 32'd0);
    chk("valid", {31'b0, valid}, 32'd1);
    chk("vel", vel, exp_vel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step; step;
    chk("rst_vel", vel, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdat", rdat, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    wb_read(REG_PERIOD, d);   chk("period_default", d, 32'd100000);

    wb_write(REG_PERIOD, 32'd4);
    run_window(32'd3, 32'd3);
    run_window(32'd6, 32'd3);
    run_window(32'd9, 32'd3);

    run_window(32'd4, 32'hFFFF_FFFB);
    run_window(32'hFFFF_FFFF, 32'hFFFF_FFFB);

    run_window(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_window(32'h0000_0002, 32'd4);

    run_window(32'd10, 32'd8);
    step;
    cnt_clr = 1'b1; step;
    cnt_clr = 1'b0; cnt = 32'd0; step;
    cnt = 32'd7; step;
    chk("clr_valid", {31'b0, valid}, 32'd1);
    chk("clr_vel", vel, 32'd7);
    wb_read(REG_STAT, d);   chk("stat_both", d, 32'd3);
    wb_read(REG_STAT, d);   chk("stat_cleared", d, 32'd0);
    repeat (3) step;
    wb_read(REG_STAT, d);   chk("stat_new_on_tick", d, 32'd1);
    wb_read(REG_STAT, d);   chk("stat_set_wins", d, 32'd1);
    wb_read(REG_STAT, d);   chk("stat_after_clr", d, 32'd0);

    wb_write(REG_PERIOD, 32'd0);
    wb_read(REG_PERIOD, d); chk("period_clamp", d, 32'd1);
    cnt = 32'd9;  step;
    chk("p1_valid_a", {31'b0, valid}, 32'd1);
    chk("p1_vel_a", vel, 32'd2);
    cnt = 32'd12; step;
    chk("p1_valid_b", {31'b0, valid}, 32'd1);
    chk("p1_vel_b", vel, 32'd3);
    wb_write(REG_PERIOD, 32'd4);
    chk("load_no_sample", {31'b0, valid}, 32'd0);
    run_window(32'd15, 32'd3);
    step; step;
    wb_write(REG_PERIOD, 32'd4);
    chk("restart_no_sample", {31'b0, valid}, 32'd0);
    run_window(32'd21, 32'd6);

    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {28'b0, REG_SCNT};
    chk("held_pre_ack", {31'b0, ack}, 32'd0);
    step;
    chk("held_ack1", {31'b0, ack}, 32'd1);
    chk("held_stall1", {31'b0, stall}, 32'd1);
    step;
    chk("held_idle_ack", {31'b0, ack}, 32'd0);
    chk("held_idle_stall", {31'b0, stall}, 32'd0);
    step;
    chk("held_ack2", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    step;
    chk("idle_ack", {31'b0, ack}, 32'd0);
    chk("idle_rdat", rdat, 32'd0);

    cyc = 1'b1; stb = 1'b1; addr = {28'b0, REG_VEL};
    step;
    chk("pre_rst_ack", {31'b0, ack}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_in_ack_ack", {31'b0, ack}, 32'd0);
    chk("rst_in_ack_rdat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    step;
    rst = 1'b0;
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_vel", vel, 32'd0);

    wb_write(REG_PERIOD, 32'd4);
    for (int i = 1; i <= 5; i++) run_window(32'd21 + 32'(i), 32'd1);
    wb_read(REG_SCNT, d);   chk("scnt5", d, 32'd5);
    wb_write(REG_VEL, 32'd1234);
    wb_read(REG_VEL, d);    chk("ro_write_ignored", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
